syn_update: RTL and testbench
=============================

# syn_update

Synaptic update processor: sits directly downstream of the fire FIFO and drains it once per time step. For each fired source tag it reads one weight row (source to every destination) from the synaptic weight memory and adds each weight into a per-neuron signed input-current accumulator. The neuron update stage reads the accumulators through a combinational read port once `done` pulses.

## Interface

**Parameters**
- `numneurons`, 2: number of neurons, which is also the number of accumulators and the row length.
- `tagbits`, 1: neuron tag width; `numneurons <= 2**tagbits`.
- `wbits`, 8: signed weight width.
- `accbits`, 16: signed accumulator width; `accbits >= wbits`.

**Ports**
- `clk` (in, 1): rising-edge clock.
- `asyn_reset_n` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): begin the synaptic phase of a time step.
- `fifo_empty` (in, 1): fire FIFO empty flag.
- `fifo_tag` (in, `tagbits`): head tag of the fire FIFO.
- `fifo_deq` (out, 1): dequeue strobe to the fire FIFO.
- `w_rd` (out, 1): weight memory read enable.
- `w_addr` (out, `2*tagbits`): `{src, dst}`, with src in the MSBs.
- `w_data` (in, `wbits`): signed weight, valid the cycle after `w_rd`.
- `cur_addr` (in, `tagbits`): accumulator read index.
- `cur_data` (out, `accbits`): `acc[cur_addr]`, combinational; 0 if `cur_addr >= numneurons`.
- `busy` (out, 1): high from the first cycle after `start` is accepted until the DONE state is exited.
- `done` (out, 1): one-cycle completion pulse.

## Operation

- **Reset values.** The FSM goes to IDLE. All accumulators are 0. `fifo_deq`, `w_rd`, `busy` and `done` are 0. `w_addr` is 0. The pipeline valid bit is 0.
- **Reset mid-operation.** The same values apply immediately. Partially accumulated data is lost. Tags already dequeued are not replayed.
- **FSM states:** IDLE, POP, SCAN, DONE.
- **IDLE**
  - If `start` is high, clear every accumulator at this edge and go to POP.
  - If `start` is low, stay in IDLE.
- **POP**
  - If `fifo_empty` is high, go to DONE.
  - Otherwise, assert `fifo_deq` combinationally this cycle and latch `src <= fifo_tag`.
    - If `fifo_tag < numneurons`: set `dst <= 0` and go to SCAN.
    - If `fifo_tag >= numneurons`: discard the tag, issue no reads, and stay in POP.
- **SCAN**
  - Each cycle: `w_rd = 1`, `w_addr = {src, dst}`.
  - `dst` increments each cycle. After issuing `dst == numneurons-1`, go to POP.
- **Accumulate pipeline**
  - A valid bit and `dst_d` are registered from `w_rd` and `dst`.
  - When the valid bit is set, `acc[dst_d] <= acc[dst_d] + sext(w_data)` at the next edge. This is independent of FSM state.
  - The read-modify-write completes in one cycle, so there is no hazard.
- **DONE**
  - `done = 1` for one cycle, then go to IDLE.
  - The last accumulate has already landed because POP consumed at least one cycle after the final SCAN cycle.
- **Start handling.** `start` is ignored outside IDLE.
- **Producer concurrency.** The producer may enqueue while POP is active; those tags are processed in the same time step. `fifo_deq` is never asserted while `fifo_empty` is high.
- **Self-synapses** are not special-cased: the weight memory content decides.

## Timing

- `start` accepted at edge 0 → `busy = 1` from cycle 1.
- Cost per valid tag: 1 POP cycle + `numneurons` SCAN cycles.
- Total for K valid tags: `busy` lasts `K*(1+numneurons) + 2` cycles, with `done` in the last one.
- Weight read latency is fixed at 1 cycle. `w_data` is sampled only on the cycle after `w_rd`.
- `cur_data` is combinational from `cur_addr`, so the accumulator value is visible in the same cycle the index is applied.

## Configuration

- **`SYN_SATURATE_EN` defined:** each accumulate saturates to `[-2**(accbits-1), 2**(accbits-1)-1]`. Overflow is detected from the sign bits of the operands and the sum.
- **`SYN_SATURATE_EN` undefined:** two's-complement wrap-around with no clamp logic.

## Test plan

All scenarios use `numneurons=4`, `tagbits=2`, `wbits=8`, `accbits=12`, and a weight memory model with 1-cycle latency.

- **Empty FIFO.** `start` with `fifo_empty=1` → `done` 2 cycles after start, no `fifo_deq`, no `w_rd`, all `cur_data = 0`.
- **Single tag 2.** Row `{5, -3, 0, 127}` → `fifo_deq` for exactly 1 cycle; `w_addr` sequence 8, 9, 10, 11; accumulators `{5, -3, 0, 127}`; `done` at cycle 7.
- **Tags 1 then 1.** Row 1 is `{10, 20, -30, 1}` → accumulators `{20, 40, -60, 2}`; `busy` for 12 cycles.
- **Saturation.** Weight 127 added 20 times to acc[0] → 2047 with `SYN_SATURATE_EN`; -1556 without it.
- **Invalid tag, then reset.** Tag 3 with `numneurons=3` → dequeued, no `w_rd`. Separately, assert `asyn_reset_n=0` mid-SCAN → outputs zero immediately and the FSM is in IDLE.
- **Start between runs and in IDLE.** `start` after a completed run → accumulators cleared before new sums. `start` held during `busy` → no restart.

Source files
------------

// File: rtl/syn_update.sv
// Synaptic update processor: drains the fire FIFO and accumulates each fired weight row into per-neuron currents.
// Optional build macro: SYN_SATURATE_EN (saturating accumulate instead of two's-complement wrap).
module syn_update #(
    parameter int numneurons = 2,
    parameter int tagbits    = 1,
    parameter int wbits      = 8,
    parameter int accbits    = 16
) (
    input  logic                   clk,
    input  logic                   asyn_reset_n,
    input  logic                   start,
    input  logic                   fifo_empty,
    input  logic [tagbits-1:0]     fifo_tag,
    output logic                   fifo_deq,
    output logic                   w_rd,
    output logic [2*tagbits-1:0]   w_addr,
    input  logic [wbits-1:0]       w_data,
    input  logic [tagbits-1:0]     cur_addr,
    output logic [accbits-1:0]     cur_data,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned          NUM      = numneurons;
    localparam logic [tagbits:0]     NUM_EXT  = (tagbits+1)'(numneurons);
    localparam logic [tagbits-1:0]   LAST_DST = tagbits'(numneurons - 1);

    typedef enum logic [1:0] {IDLE, POP, SCAN, DONE} state_t;

    state_t                     state;
    logic [tagbits-1:0]         src;
    logic [tagbits-1:0]         dst;
    logic [tagbits-1:0]         dst_d;
    logic                       vld;
    logic signed [accbits-1:0]  acc [numneurons];

    logic                       tag_ok;
    logic signed [accbits-1:0]  wext;
    logic signed [accbits-1:0]  acc_cur;
    logic signed [accbits-1:0]  sum;
    logic signed [accbits-1:0]  acc_next;

    assign tag_ok   = ({1'b0, fifo_tag} < NUM_EXT);
    assign fifo_deq = (state == POP) && !fifo_empty;
    assign w_rd     = (state == SCAN);
    assign w_addr   = (state == SCAN) ? {src, dst} : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        wext    = accbits'($signed(w_data));
        acc_cur = acc[dst_d];
        sum     = acc_cur + wext;
        acc_next = sum;
`ifdef SYN_SATURATE_EN
        // Overflow only when both operands share a sign that the sum does not.
        if ((acc_cur[accbits-1] == wext[accbits-1]) && (sum[accbits-1] != acc_cur[accbits-1]))
            acc_next = acc_cur[accbits-1] ? {1'b1, {(accbits-1){1'b0}}}
                                          : {1'b0, {(accbits-1){1'b1}}};
`endif
    end

    always_comb begin
        cur_data = '0;
        if ({1'b0, cur_addr} < NUM_EXT)
            cur_data = acc[cur_addr];
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            dst_d <= '0;
            vld   <= 1'b0;
            for (int unsigned i = 0; i < NUM; i++)
                acc[i] <= '0;
        end else begin
            vld   <= (state == SCAN);
            dst_d <= dst;
            if (vld)
                acc[dst_d] <= acc_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NUM; i++)
                            acc[i] <= '0;
                        state <= POP;
                    end
                end
                POP: begin
                    if (fifo_empty) begin
                        state <= DONE;
                    end else begin
                        src <= fifo_tag;
                        // Out-of-range tags are consumed without issuing any reads.
                        if (tag_ok) begin
                            dst   <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    dst <= dst + 1'b1;
                    if (dst == LAST_DST)
                        state <= POP;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_update.sv
// Self-checking bench for syn_update: table vectors, multi-cycle corner sequences and randomized runs against a row-sum model.
module tb_syn_update;

    logic        clk = 1'b0;
    logic        asyn_reset_n;
    logic        start;
    logic        fifo_empty;
    logic [1:0]  fifo_tag;
    logic        fifo_deq;
    logic        w_rd;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [1:0]  cur_addr;
    logic [11:0] cur_data;
    logic        busy;
    logic        done;

    logic        start3, fifo3_empty, fifo3_deq, w3_rd, busy3, done3;
    logic [1:0]  fifo3_tag, cur3_addr;
    logic [3:0]  w3_addr;
    logic [7:0]  w3_data;
    logic [11:0] cur3_data;

    syn_update #(.numneurons(4), .tagbits(2), .wbits(8), .accbits(12)) u_dut (
        .clk(clk), .asyn_reset_n(asyn_reset_n), .start(start),
        .fifo_empty(fifo_empty), .fifo_tag(fifo_tag), .fifo_deq(fifo_deq),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .cur_addr(cur_addr), .cur_data(cur_data), .busy(busy), .done(done)
    );

    syn_update #(.numneurons(3), .tagbits(2), .wbits(8), .accbits(12)) u_dut3 (
        .clk(clk), .asyn_reset_n(asyn_reset_n), .start(start3),
        .fifo_empty(fifo3_empty), .fifo_tag(fifo3_tag), .fifo_deq(fifo3_deq),
        .w_rd(w3_rd), .w_addr(w3_addr), .w_data(w3_data),
        .cur_addr(cur3_addr), .cur_data(cur3_data), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    // Fire FIFO: tags written by the stimulus thread, read pointer advanced on dequeue.
    logic [1:0] tagmem [256];
    logic [7:0] wrp = '0;
    logic [7:0] rdp = '0;
    assign fifo_empty = (rdp == wrp);
    assign fifo_tag   = tagmem[rdp];

    logic [7:0] wmem [16];
    int deq_cnt = 0, wrd_cnt = 0, alog_n = 0, bad_deq = 0, deq3_cnt = 0, w3_cnt = 0;
    logic [3:0] addr_log [64];

    always @(posedge clk) begin
        if (fifo_deq) rdp <= rdp + 8'd1;
        if (fifo_deq) deq_cnt <= deq_cnt + 1;
        if (fifo_deq && fifo_empty) bad_deq <= bad_deq + 1;
        if (w_rd) begin
            wrd_cnt <= wrd_cnt + 1;
            addr_log[alog_n & 63] <= w_addr;
            alog_n <= alog_n + 1;
        end
        w_data <= w_rd ? wmem[w_addr] : 8'($urandom);
        if (fifo3_deq) deq3_cnt <= deq3_cnt + 1;
        if (w3_rd) w3_cnt <= w3_cnt + 1;
    end

    int checks = 0, errors = 0;
    int exp_tags [$];

    typedef struct {
        int              k;
        logic [3:0][1:0] tags;
        int              done_c;
        int              a0, a1, a2, a3;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int t);
        tagmem[wrp] = 2'(t);
        wrp = wrp + 8'd1;
        exp_tags.push_back(t);
    endtask

    task automatic read_acc(input int a, output int v);
        cur_addr = 2'(a);
        #1;
        v = int'($signed(cur_data));
    endtask

    function automatic int add_model(input int a, input int w);
        int s;
        s = a + w;
`ifdef SYN_SATURATE_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
`else
        s = s & 32'hFFF;
        if (s >= 2048) s = s - 4096;
`endif
        return s;
    endfunction

    function automatic logic [3:0][1:0] mk_tags(input int t0, input int t1, input int t2, input int t3);
        logic [3:0][1:0] r;
        r[0] = 2'(t0); r[1] = 2'(t1); r[2] = 2'(t2); r[3] = 2'(t3);
        return r;
    endfunction

    task automatic set_row(input int s, input int w0, input int w1, input int w2, input int w3);
        wmem[s*4+0] = 8'(w0); wmem[s*4+1] = 8'(w1);
        wmem[s*4+2] = 8'(w2); wmem[s*4+3] = 8'(w3);
    endtask

    task automatic run(input bit hold, output int done_cyc, output int busy_cnt);
        int cyc;
        done_cyc = -1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (!hold) start = 1'b0;
        while (cyc < 400) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
    endtask

    task automatic run_and_check(input string nm, input int k, input int exp_done,
                                 input int e [4], input bit chk_addr, input bit hold);
        int dc, bc, d0, w0, a0, v;
        d0 = deq_cnt; w0 = wrd_cnt; a0 = alog_n;
        run(hold, dc, bc);
        check({nm, "_done_cycle"}, dc, exp_done);
        check({nm, "_busy_cycles"}, bc, exp_done);
        check({nm, "_deq_count"}, deq_cnt - d0, k);
        check({nm, "_wrd_count"}, wrd_cnt - w0, 4*k);
        if (chk_addr)
            for (int j = 0; j < 4*k; j++)
                check($sformatf("%s_waddr%0d", nm, j), int'(addr_log[(a0+j) & 63]),
                      exp_tags[j/4]*4 + (j%4));
        for (int d = 0; d < 4; d++) begin
            read_acc(d, v);
            check($sformatf("%s_acc%0d", nm, d), v, e[d]);
        end
    endtask

    initial begin
        int v, dc, bc, k, d0, t;
        int e [4];

        vecs[0] = '{k:0, tags:mk_tags(0,0,0,0), done_c:2,  a0:0,    a1:0,  a2:0,   a3:0};
        vecs[1] = '{k:1, tags:mk_tags(2,0,0,0), done_c:7,  a0:5,    a1:-3, a2:0,   a3:127};
        vecs[2] = '{k:2, tags:mk_tags(1,1,0,0), done_c:12, a0:20,   a1:40, a2:-60, a3:2};
        vecs[3] = '{k:2, tags:mk_tags(2,1,0,0), done_c:12, a0:15,   a1:17, a2:-30, a3:128};
        vecs[4] = '{k:3, tags:mk_tags(0,3,2,0), done_c:17, a0:-122, a1:-2, a2:67,  a3:124};
        vecs[5] = '{k:4, tags:mk_tags(3,3,3,3), done_c:22, a0:-512, a1:-4, a2:256, a3:-28};

        for (int i = 0; i < 256; i++) tagmem[i] = '0;
        set_row(0, 1, 2, 3, 4);
        set_row(1, 10, 20, -30, 1);
        set_row(2, 5, -3, 0, 127);
        set_row(3, -128, -1, 64, -7);

        asyn_reset_n = 1'b0; start = 1'b0; cur_addr = '0;
        start3 = 1'b0; fifo3_empty = 1'b1; fifo3_tag = '0; cur3_addr = '0; w3_data = '0;
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wrd", int'(w_rd), 0);
        check("rst_deq", int'(fifo_deq), 0);
        check("rst_waddr", int'(w_addr), 0);
        for (int d = 0; d < 4; d++) begin
            read_acc(d, v);
            check($sformatf("rst_acc%0d", d), v, 0);
        end
        @(negedge clk);
        asyn_reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            exp_tags.delete();
            for (int j = 0; j < vecs[i].k; j++) push(int'(vecs[i].tags[j]));
            run_and_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].done_c,
                          '{vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3}, 1'b1, 1'b0);
        end

        // Producer enqueues a second tag while the first row is being scanned.
        exp_tags.delete();
        push(2);
        fork
            run_and_check("concurrent", 2, 12, '{15, 17, -30, 128}, 1'b1, 1'b0);
            begin
                repeat (3) @(negedge clk);
                push(1);
            end
        join

        // Start held high throughout the busy window must not restart the phase.
        exp_tags.delete();
        push(1);
        run_and_check("hold_start", 1, 7, '{10, 20, -30, 1}, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a scan.
        exp_tags.delete();
        push(2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("midscan_wrd", int'(w_rd), 1);
        read_acc(0, v);
        check("midscan_acc0", v, 5);
        asyn_reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_wrd", int'(w_rd), 0);
        check("arst_waddr", int'(w_addr), 0);
        check("arst_done", int'(done), 0);
        read_acc(0, v);
        check("arst_acc0", v, 0);
        @(negedge clk);
        asyn_reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_arst_busy", int'(busy), 0);
        for (int d = 0; d < 4; d++) begin
            read_acc(d, v);
            check($sformatf("post_arst_acc%0d", d), v, 0);
        end

        // Out-of-range tag on a 3-neuron instance: dequeued once, never read.
        d0 = deq3_cnt;
        @(negedge clk);
        fifo3_empty = 1'b0; fifo3_tag = 2'd3; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("inv_deq_c1", int'(fifo3_deq), 1);
        @(negedge clk);
        fifo3_empty = 1'b1;
        dc = -1;
        for (int c = 2; c < 20; c++) begin
            if (done3) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
        check("inv_done_cycle", dc, 3);
        check("inv_deq_count", deq3_cnt - d0, 1);
        check("inv_wrd_count", w3_cnt, 0);
        cur3_addr = 2'd3;
        #1;
        check("inv_cur_oob", int'(cur3_data), 0);

        // Repeated large weight into acc[0].
        wmem[0] = 8'd127;
        exp_tags.delete();
        for (int j = 0; j < 20; j++) push(0);
`ifdef SYN_SATURATE_EN
        run_and_check("sat", 20, 102, '{2047, 40, 60, 80}, 1'b0, 1'b0);
`else
        run_and_check("sat", 20, 102, '{-1556, 40, 60, 80}, 1'b0, 1'b0);
`endif

        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < 16; a++) wmem[a] = 8'($urandom);
            exp_tags.delete();
            k = $urandom_range(0, 6);
            e = '{0, 0, 0, 0};
            for (int j = 0; j < k; j++) begin
                t = $urandom_range(0, 3);
                push(t);
                for (int d = 0; d < 4; d++)
                    e[d] = add_model(e[d], int'($signed(wmem[t*4+d])));
            end
            run_and_check($sformatf("rnd%0d", it), k, k*5 + 2, e, 1'b1, 1'b0);
        end

        check("deq_while_empty", bad_deq, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
